// File: rtl/div_pkg.sv
// Package: div_pkg
// Shared types and defaults for the sequential restoring divider.
//   div_state_t        : FSM state encoding (IDLE, LOAD, CALC, DONE)
//   DIV_WIDTH_DEFAULT  : default operand/result width
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CALC,
        DONE
    } div_state_t;

    localparam int DIV_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/div_step.sv
// Module: div_step
// One combinational restoring-division iteration: shift {R,Q} left by one,
// trial-subtract the divisor from the shifted remainder, and keep the
// difference (shifting a 1 into Q) when it is non-negative.
// Ports:
//   i_rem      in   WIDTH  partial remainder R (always < divisor, so the
//                          WIDTH+1-bit register's top bit is zero and is not carried)
//   i_quo      in   WIDTH  partial quotient / remaining dividend bits Q
//   i_divisor  in   WIDTH  divisor magnitude
//   o_rem      out  WIDTH  next partial remainder
//   o_quo      out  WIDTH  next partial quotient
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);

    logic [WIDTH:0] w_rem_sh;
    logic [WIDTH:0] w_diff;

    // Shifted remainder needs WIDTH+1 bits: R < divisor, so 2R+1 < 2^(WIDTH+1).
    assign w_rem_sh = {i_rem, i_quo[WIDTH-1]};

    // Two's-complement subtract: invert the zero-extended divisor, carry-in 1.
    // The top bit of the difference is the borrow (1 = shifted R < divisor).
    assign w_diff = w_rem_sh + ~{1'b0, i_divisor} + {{WIDTH{1'b0}}, 1'b1};

    assign o_rem = w_diff[WIDTH] ? w_rem_sh[WIDTH-1:0] : w_diff[WIDTH-1:0];
    assign o_quo = {i_quo[WIDTH-2:0], ~w_diff[WIDTH]};

endmodule

// File: rtl/seq_divider.sv
// Module: seq_divider
// Sequential shift-subtract (restoring) divider, one quotient bit per clock.
// Sequence: IDLE -> LOAD -> CALC (WIDTH cycles) -> DONE -> IDLE; a zero
// divisor skips CALC and reports all-ones quotient, remainder = dividend.
// Optional feature macro: SIGNED_DIV_EN (two's-complement operands via a
// magnitude/sign wrapper around the unsigned core; quotient truncates toward
// zero, remainder takes the dividend's sign). Undefined = unsigned only.
// Ports:
//   clk          in   1      rising-edge clock
//   reset        in   1      asynchronous active-low reset
//   start        in   1      request a division (sampled only in IDLE)
//   dividend     in   WIDTH  numerator, captured on the accepting edge
//   divisor      in   WIDTH  denominator, captured on the accepting edge
//   busy         out  1      high in LOAD, CALC and DONE
//   done         out  1      one-cycle pulse in DONE; results valid from here
//   quotient     out  WIDTH  result, held until the next result is written
//   remainder    out  WIDTH  result, held until the next result is written
//   div_by_zero  out  1      set with done on a zero divisor; cleared on accept
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH);

    div_state_t       r_state;
    div_state_t       w_state_next;

    logic [WIDTH-1:0] r_dividend;
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_div_by_zero;

    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quo_next;
    logic [WIDTH-1:0] w_quo_res;
    logic [WIDTH-1:0] w_rem_res;
    logic             w_dvs_zero;

    assign w_dvs_zero = (r_divisor == '0);

`ifdef SIGNED_DIV_EN
    logic r_sign_q;
    logic r_sign_r;

    // Core works on magnitudes; -2^(WIDTH-1) maps to 2^(WIDTH-1) unsigned.
    assign w_dvd_mag = r_dividend[WIDTH-1] ? -r_dividend : r_dividend;
    assign w_dvs_mag = r_divisor[WIDTH-1]  ? -r_divisor  : r_divisor;
    assign w_quo_res = r_sign_q ? -w_quo_next : w_quo_next;
    assign w_rem_res = r_sign_r ? -w_rem_next : w_rem_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
        end else if (r_state == LOAD) begin
            r_sign_q <= r_dividend[WIDTH-1] ^ r_divisor[WIDTH-1];
            r_sign_r <= r_dividend[WIDTH-1];
        end
    end
`else
    assign w_dvd_mag = r_dividend;
    assign w_dvs_mag = r_divisor;
    assign w_quo_res = w_quo_next;
    assign w_rem_res = w_rem_next;
`endif

    div_step #(
        .WIDTH     (WIDTH)
    ) u_step (
        .i_rem     (r_rem),
        .i_quo     (r_quo),
        .i_divisor (w_dvs_mag),
        .o_rem     (w_rem_next),
        .o_quo     (w_quo_next)
    );

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent behaviour.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: next state defaults to the current state before the case so every
    // path assigns it and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = LOAD;
            LOAD:    w_state_next = w_dvs_zero ? DONE : CALC;
            CALC:    if (r_cnt == '0) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // NOTE: operand and working registers are reset too; they are few, and a
    // known value keeps the outputs at zero after reset without extra gating.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dividend    <= '0;
            r_divisor     <= '0;
            r_rem         <= '0;
            r_quo         <= '0;
            r_cnt         <= '0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_dividend    <= dividend;
                        r_divisor     <= divisor;
                        r_div_by_zero <= 1'b0;
                    end
                end
                LOAD: begin
                    r_rem <= '0;
                    r_quo <= w_dvd_mag;
                    r_cnt <= CNT_W'(WIDTH - 1);
                    if (w_dvs_zero) begin
                        r_quotient    <= '1;
                        r_remainder   <= r_dividend;
                        r_div_by_zero <= 1'b1;
                    end
                end
                CALC: begin
                    r_rem <= w_rem_next;
                    r_quo <= w_quo_next;
                    r_cnt <= r_cnt - CNT_W'(1);
                    // Publish on the last iteration so results are valid in DONE.
                    if (r_cnt == '0) begin
                        r_quotient  <= w_quo_res;
                        r_remainder <= w_rem_res;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = (r_state != IDLE);
    assign done        = (r_state == DONE);
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_div_by_zero;

endmodule
